// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the pipelined RV32 core. It consumes a
// length-prefixed, XOR-checksummed byte stream over a valid/ready handshake,
// packs the bytes little-endian into 32-bit words and writes them one by one
// into the instruction memory write port. The core is held in reset until the
// whole image has arrived and the checksum matches.
//
// Stream: LEN_LO, LEN_HI (word count N), 4*N data bytes (LSB first per word),
//         then one checksum byte = XOR of every preceding byte.
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   reset         synchronous active-high reset
//   in_valid      a stream byte is present on in_data
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   imem_we       instruction memory write strobe, one cycle per word
//   imem_addr     word index being written
//   imem_wdata    word being written
//   core_reset    hold-reset for the datapath, drops once the load succeeds
//   done          image loaded and checksum good
//   error         oversize length or checksum mismatch
//   loaded_words  number of words written so far
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   loaded_words
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        lane_q, lane_d;
    // Only the first three bytes of a word need holding; the fourth byte is
    // taken straight from in_data when the word is issued.
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    // Doubles as the write pointer: the next word goes to loaded_words.
    logic [ADDR_W:0]   loaded_q, loaded_d;

    logic              accept;
    logic [15:0]       len_full;

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                S_LEN0, S_LEN1, S_DATA, S_CSUM: in_ready = 1'b1;
                default:                        in_ready = 1'b0;
            endcase
        end
    end

    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, len_q[7:0]};

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        xor_d        = xor_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        error_d      = error_q;
        loaded_d     = loaded_q;

        if (accept) begin
            case (state_q)
                S_LEN0: begin
                    len_d   = {8'h00, in_data};
                    xor_d   = xor_q ^ in_data;
                    state_d = S_LEN1;
                end
                S_LEN1: begin
                    len_d = len_full;
                    xor_d = xor_q ^ in_data;
                    if (32'(len_full) > 32'(DEPTH)) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else if (len_full == 16'h0000) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    xor_d  = xor_q ^ in_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        we_d     = 1'b1;
                        addr_d   = loaded_q[ADDR_W-1:0];
                        wdata_d  = {in_data, asm_q};
                        loaded_d = loaded_q + 1'b1;
                        if (32'(loaded_q) + 32'd1 == 32'(len_q)) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        asm_d = {in_data, asm_q[23:8]};
                    end
                end
                S_CSUM: begin
                    // The checksum byte itself is never folded into the XOR.
                    if (in_data == xor_q) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        core_reset_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LEN0;
            len_q        <= '0;
            lane_q       <= '0;
            asm_q        <= '0;
            xor_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            loaded_q     <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            xor_q        <= xor_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
            loaded_q     <= loaded_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_reset   = core_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign loaded_words = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed stimulus for imem_loader. A stream-level model (indexed by byte
// position in the accepted stream) predicts every output each cycle; a handful
// of literal expectations pin the nominal image, zero-length, oversize,
// bad-checksum, gapped, mid-load reset and N == DEPTH cases.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   loaded_words;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .loaded_words (loaded_words)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [7:0]  nom[$] = '{8'h03, 8'h00, 8'h13, 8'h01, 8'h01, 8'hfe, 8'h23, 8'h26,
                            8'h81, 8'h02, 8'h13, 8'h04, 8'h01, 8'h03, 8'h7d};
    logic [7:0]  stim[$];
    logic [39:0] wlog[$];   // {addr, data} of every observed write

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stream-level model ----------------
    logic [7:0]  m_buf[$];
    int          m_n      = 0;
    bit          m_done   = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_we     = 1'b0;
    int          m_addr   = 0;
    logic [31:0] m_wdata  = '0;
    int          m_loaded = 0;

    always @(posedge clk) begin
        int k;
        logic [7:0] x;
        m_we = 1'b0;
        if (reset) begin
            m_buf.delete();
            m_n = 0; m_done = 1'b0; m_err = 1'b0; m_loaded = 0;
        end else if (in_valid && !m_done && !m_err) begin
            m_buf.push_back(in_data);
            k = m_buf.size() - 1;
            if (k == 1) begin
                m_n = int'(m_buf[0]) + 256 * int'(m_buf[1]);
                if (m_n > DEPTH) m_err = 1'b1;
            end else if (k >= 2 && k < 2 + 4 * m_n) begin
                if ((k - 2) % 4 == 3) begin
                    m_we     = 1'b1;
                    m_addr   = (k - 2) / 4;
                    m_wdata  = {m_buf[k], m_buf[k-1], m_buf[k-2], m_buf[k-3]};
                    m_loaded = m_loaded + 1;
                end
            end else if (k >= 2) begin
                x = 8'h00;
                for (int i = 0; i < k; i++) x = x ^ m_buf[i];
                if (x == m_buf[k]) m_done = 1'b1;
                else               m_err  = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(!reset && !m_done && !m_err));
            chk("imem_we", 64'(imem_we), 64'(m_we));
            if (m_we) begin
                chk("imem_addr", 64'(imem_addr), 64'(m_addr));
                chk("imem_wdata", 64'(imem_wdata), 64'(m_wdata));
            end
            chk("done", 64'(done), 64'(m_done));
            chk("error", 64'(error), 64'(m_err));
            chk("core_reset", 64'(core_reset), 64'(!m_done));
            chk("loaded_words", 64'(loaded_words), 64'(m_loaded));
            if (imem_we === 1'b1) begin
                wlog.push_back({imem_addr, imem_wdata});
                $display("[TB] write addr=%0d data=%08h", imem_addr, imem_wdata);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  waited;
        bit  acc;
        in_valid = 1'b0;
        tick(gap);
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 64) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL accept_timeout: byte %02h got no in_ready expected accept", b);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_stim(input bit gaps, input int limit);
        int gap;
        for (int i = 0; i < stim.size() && i < limit; i++) begin
            gap = 0;
            if (gaps) begin
                gap = i % 2;
                if ($urandom_range(0, 3) == 0) gap += int'($urandom_range(1, 3));
            end
            send_byte(stim[i], gap);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_imem_we", 64'(imem_we), 64'(0));
        chk("rst_imem_addr", 64'(imem_addr), 64'(0));
        chk("rst_imem_wdata", 64'(imem_wdata), 64'(0));
        chk("rst_core_reset", 64'(core_reset), 64'(1));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_loaded", 64'(loaded_words), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        wlog.delete();
    endtask

    task automatic check_nominal_words(input string tag);
        chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(3));
        if (wlog.size() == 3) begin
            chk({tag, "_w0"}, 64'(wlog[0]), 64'(40'h00_fe010113));
            chk({tag, "_w1"}, 64'(wlog[1]), 64'(40'h01_02812623));
            chk({tag, "_w2"}, 64'(wlog[2]), 64'(40'h02_03010413));
        end
    endtask

    task automatic check_final(input string tag, input bit d, input bit e, input int lw);
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'(d));
        chk({tag, "_error"}, 64'(error), 64'(e));
        chk({tag, "_core_reset"}, 64'(core_reset), 64'(!d));
        chk({tag, "_loaded"}, 64'(loaded_words), 64'(lw));
        @(posedge clk);
        #1;
    endtask

    initial begin
        time t0, t_nom, t_gap;
        logic [7:0] x;
        logic [7:0] b;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        do_reset();

        $display("[TB] stream: nominal 3-word image");
        stim = nom;
        t0 = $time;
        send_stim(1'b0, 1000);
        t_nom = $time - t0;
        tick(2);
        check_nominal_words("nominal");
        check_final("nominal", 1'b1, 1'b0, 3);

        $display("[TB] stream: zero length");
        do_reset();
        stim = '{8'h00, 8'h00, 8'h00};
        send_stim(1'b0, 1000);
        tick(2);
        chk("zero_nwrites", 64'(wlog.size()), 64'(0));
        check_final("zero", 1'b1, 1'b0, 0);

        $display("[TB] stream: oversize N=257");
        do_reset();
        stim = '{8'h01, 8'h01};
        send_stim(1'b0, 1000);
        in_valid = 1'b1;
        in_data  = 8'h13;
        tick(5);
        in_valid = 1'b0;
        chk("oversize_nwrites", 64'(wlog.size()), 64'(0));
        check_final("oversize", 1'b0, 1'b1, 0);

        $display("[TB] stream: bad checksum");
        do_reset();
        stim = nom;
        stim[14] = 8'h7c;
        send_stim(1'b0, 1000);
        tick(2);
        check_nominal_words("badcsum");
        check_final("badcsum", 1'b0, 1'b1, 3);

        $display("[TB] stream: nominal with gaps");
        do_reset();
        stim = nom;
        t0 = $time;
        send_stim(1'b1, 1000);
        t_gap = $time - t0;
        tick(2);
        check_nominal_words("gaps");
        check_final("gaps", 1'b1, 1'b0, 3);
        chk("gaps_later", 64'(t_gap > t_nom), 64'(1));

        $display("[TB] stream: reset after 6 data bytes");
        do_reset();
        stim = nom;
        send_stim(1'b0, 8);
        tick(1);
        chk("midrst_nwrites", 64'(wlog.size()), 64'(1));
        if (wlog.size() == 1) chk("midrst_w0", 64'(wlog[0]), 64'(40'h00_fe010113));
        do_reset();
        chk("midrst_after_nwrites", 64'(wlog.size()), 64'(0));
        send_stim(1'b0, 1000);
        tick(2);
        check_nominal_words("midrst");
        check_final("midrst", 1'b1, 1'b0, 3);

        $display("[TB] stream: N == DEPTH");
        do_reset();
        stim = '{8'h00, 8'h01};
        x = 8'h00 ^ 8'h01;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            b = 8'((i * 37 + 11) ^ (i >> 3));
            stim.push_back(b);
            x = x ^ b;
        end
        stim.push_back(x);
        send_stim(1'b0, 100000);
        tick(2);
        chk("depth_nwrites", 64'(wlog.size()), 64'(DEPTH));
        if (wlog.size() == DEPTH) begin
            chk("depth_first_addr", 64'(wlog[0][39:32]), 64'(0));
            chk("depth_last_addr", 64'(wlog[DEPTH-1][39:32]), 64'(DEPTH - 1));
        end
        check_final("depth", 1'b1, 1'b0, DEPTH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the pipelined RV32 core. Accepts a length-prefixed, checksummed byte stream over a valid/ready interface, packs bytes little-endian into 32-bit words and writes them sequentially into the instruction memory's write port. It holds the core in reset until the image is fully and correctly loaded. It replaces hierarchical preloading of instruction memory.

## Interface
Parameters:
- ADDR_W, 8: instruction memory word-address width.
- DEPTH, 2**ADDR_W: maximum number of words accepted; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word index being written.
- imem_wdata  output  32  word being written.
- core_reset  output  1  hold-reset to datapath; high until load succeeds.
- done  output  1  image loaded and checksum good.
- error  output  1  load failed (oversize length or checksum mismatch).
- loaded_words  output  ADDR_W+1  number of words written so far.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N data bytes (each word LSB first), then one checksum byte = XOR of all preceding bytes, including length bytes.
- Byte accepted on a rising edge where in_valid && in_ready. in_data is ignored otherwise.
- States: LEN0 → LEN1 → DATA → CSUM → DONE, with ERR as an alternative terminal state.
  - LEN0: accept LEN_LO → LEN1.
  - LEN1: accept LEN_HI. If N > DEPTH → ERR. If N == 0 → CSUM. Otherwise → DATA.
  - DATA: byte lane counter 0..3 fills a 32-bit shift/assembly register. On the 4th byte, issue a write and increment the word index. After word N−1's 4th byte → CSUM.
  - CSUM: accept one byte. If it equals the running XOR → DONE, else → ERR.
  - DONE and ERR: terminal; left only via reset.
- in_ready = !reset && state ∈ {LEN0, LEN1, DATA, CSUM}.
- Running XOR clears to 0 on reset and folds in every accepted byte except the checksum byte.
- Words written before an error remain in memory. The loader never rewrites them.
- loaded_words increments in the same cycle imem_we is high. It saturates at N.

## Timing
- Reset values (registered, also forced while reset is high):
  - state = LEN0
  - imem_we = 0, imem_addr = 0, imem_wdata = 0
  - core_reset = 1, done = 0, error = 0
  - loaded_words = 0, XOR = 0, lane = 0
  - in_ready = 0
- in_ready first rises the cycle after reset is deasserted.
- Write latency: imem_we is high for exactly the one cycle after the edge that accepted a word's 4th byte. imem_addr and imem_wdata are valid in that same cycle. Memory captures on the following edge.
- Maximum throughput is one byte per cycle with no bubbles. in_valid gaps simply stall the FSM. Lane and XOR hold during gaps.
- done and core_reset:
  - done rises, and core_reset falls, the cycle after the checksum byte is accepted.
  - Both are registered and glitch-free.
  - The last data write always precedes done by at least one cycle.
- error rises the cycle after the offending byte is accepted (LEN_HI or checksum). core_reset stays 1.
- Reset mid-load aborts immediately. On the next cycle all outputs are at reset values and the loader expects LEN_LO. Any partially assembled word is discarded and never written.
- Boundary N == DEPTH is legal. Write addresses run 0..DEPTH−1 with no wrap. N == DEPTH+1 → ERR.

## Test plan
- **Nominal 3-word image.** Stream 03 00 13 01 01 fe 23 26 81 02 13 04 01 03 7d, in_valid held high.
  - Writes expected: addr 0 = fe010113, addr 1 = 02812623, addr 2 = 03010413.
  - imem_we pulses exactly 3 times. loaded_words = 3.
  - done = 1 and core_reset = 0 one cycle after 7d is accepted. error = 0.
- **Zero length.** Stream 00 00 00 → no imem_we pulse, loaded_words = 0, done = 1 after the third byte.
- **Oversize.** With ADDR_W = 8, send 01 01 (N = 257) → error = 1 the cycle after LEN_HI. in_ready = 0 thereafter, no writes, core_reset = 1.
- **Bad checksum.** Send the nominal stream with final byte 7c.
  - All 3 writes still occur.
  - error = 1, done = 0, core_reset remains 1.
- **Backpressure/gaps.** Send the nominal stream with in_valid toggling every other cycle and random stalls.
  - Writes must have identical addr/data to the nominal case.
  - done must match the nominal case, with completion later by the idle cycles.
- **Reset mid-load.** Assert reset after 6 data bytes, then send the nominal stream.
  - Only the word from the first 4 bytes was written before reset; the partial second word is never written.
  - After reset: outputs at reset values.
  - The subsequent full load completes with done = 1 and the correct 3 words.
